// File: rtl/btn_press_classifier.sv
// Turns a debounced switch level into press/release ticks, gesture pulses
// (short, long, double) and a running press count.
module btn_press_classifier #(
  parameter int unsigned LONG_CYC    = 1_000_000,
  parameter int unsigned DBL_GAP_CYC = 250_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             db_in,
  output logic             press_tick,
  output logic             release_tick,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic             long_active,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
  localparam int unsigned GAP_W  = $clog2(DBL_GAP_CYC + 1);

  // Terminal values: the *_LAST constants mark the sample before the deciding one
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(DBL_GAP_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(DBL_GAP_CYC);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED   = 3'd1,
    S_LONG_HELD = 3'd2,
    S_WAIT_2ND  = 3'd3,
    S_PRESSED_2 = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              db_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_nxt;

  logic rise;
  logic fall;
  logic short_c;
  logic long_c;
  logic double_c;
  logic long_active_c;

  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;

  // State, sampled level and gesture counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      db_q     <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      db_q     <= db_in;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
    end
  end

  // Next-state and counter update; counters saturate at their terminal value
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nxt = S_PRESSED;
          hold_nxt  = HOLD_ONE;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          state_nxt = S_WAIT_2ND;
          gap_nxt   = GAP_ONE;
        end else if (db_in) begin
          if (hold_cnt >= HOLD_LAST) begin
            state_nxt = S_LONG_HELD;
            hold_nxt  = HOLD_MAX;
          end else begin
            hold_nxt = hold_cnt + HOLD_ONE;
          end
        end
      end
      S_LONG_HELD: begin
        if (fall) state_nxt = S_IDLE;
      end
      S_WAIT_2ND: begin
        if (rise) begin
          state_nxt = S_PRESSED_2;
        end else if (gap_cnt >= GAP_LAST) begin
          state_nxt = S_IDLE;
          gap_nxt   = GAP_MAX;
        end else begin
          gap_nxt = gap_cnt + GAP_ONE;
        end
      end
      S_PRESSED_2: begin
        if (fall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Gesture decisions taken on the current sample
  always_comb begin
    short_c       = 1'b0;
    long_c        = 1'b0;
    double_c      = 1'b0;
    long_active_c = (state_nxt == S_LONG_HELD);
    case (state)
      S_PRESSED:  long_c = db_in & (hold_cnt >= HOLD_LAST);
      S_WAIT_2ND: begin
        double_c = rise;
        short_c  = ~db_in & (gap_cnt >= GAP_LAST);
      end
      default: ;
    endcase
  end

  // Registered outputs, one cycle after the deciding sample
  always_ff @(posedge clk) begin
    if (rst) begin
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      long_active  <= 1'b0;
      press_cnt    <= '0;
    end else begin
      press_tick   <= rise;
      release_tick <= fall;
      short_press  <= short_c;
      long_press   <= long_c;
      double_press <= double_c;
      long_active  <= long_active_c;
      press_cnt    <= press_cnt + CNT_W'(rise);
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier: directed vector table, a reset-abort
// sequence, and random run-length stimulus against a run-based gesture model.
module tb_btn_press_classifier;

  localparam int unsigned LONG = 8;
  localparam int unsigned GAP  = 5;
  localparam int unsigned CW   = 2;
  localparam int          N    = 3000;

  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] PT = 6'b100000;
  localparam logic [5:0] RT = 6'b010000;
  localparam logic [5:0] SP = 6'b001000;
  localparam logic [5:0] LP = 6'b000100;
  localparam logic [5:0] DP = 6'b000010;
  localparam logic [5:0] LA = 6'b000001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          db_in = 1'b0;
  logic          press_tick, release_tick, short_press, long_press;
  logic          double_press, long_active;
  logic [CW-1:0] press_cnt;
  logic [7:0]    obs;

  int total = 0;
  int bad   = 0;

  btn_press_classifier #(
    .LONG_CYC(LONG), .DBL_GAP_CYC(GAP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .db_in(db_in),
    .press_tick(press_tick), .release_tick(release_tick),
    .short_press(short_press), .long_press(long_press),
    .double_press(double_press), .long_active(long_active),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {press_tick, release_tick, short_press, long_press,
                double_press, long_active, press_cnt};

  typedef struct {
    bit         r;
    bit         d;
    logic [5:0] f;
    logic [1:0] c;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit d, logic [5:0] f, logic [1:0] c, int n);
    vec_t v;
    v.r = r; v.d = d; v.f = f; v.c = c;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pt/rt/sp/lp/dp/la/cnt=%b want %b", nm, act, exp);
    end
  endtask

  task automatic step(bit r, bit d);
    rst   = r;
    db_in = d;
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state
  int  run_start[$];
  int  run_len[$];
  bit  s_arr[N];
  bit  e_pt[N], e_rt[N], e_sp[N], e_lp[N], e_dp[N], e_la[N];

  function automatic void mark_set(int idx, int kind);
    if (idx < 0 || idx >= N) return;
    case (kind)
      0: e_pt[idx] = 1'b1;
      1: e_rt[idx] = 1'b1;
      2: e_sp[idx] = 1'b1;
      3: e_lp[idx] = 1'b1;
      4: e_dp[idx] = 1'b1;
      default: e_la[idx] = 1'b1;
    endcase
  endfunction

  // Build alternating low/high runs, then classify gestures run by run
  function automatic void build_random();
    int pos = 0;
    bit lv = 1'b0;
    int g;
    while (pos < N) begin
      int l;
      l = lv ? int'($urandom_range(1, 11)) : int'($urandom_range(1, 7));
      run_start.push_back(pos);
      run_len.push_back(l);
      pos += l;
      lv = ~lv;
    end
    for (int t = 0; t < N; t++) begin
      s_arr[t] = 1'b0; e_pt[t] = 1'b0; e_rt[t] = 1'b0; e_sp[t] = 1'b0;
      e_lp[t] = 1'b0; e_dp[t] = 1'b0; e_la[t] = 1'b0;
    end
    for (int i = 0; i < run_start.size(); i++) begin
      bit hi = (i % 2) == 1;
      for (int j = 0; j < run_len[i]; j++)
        if (run_start[i] + j < N) s_arr[run_start[i] + j] = hi;
      if (i > 0) mark_set(run_start[i], hi ? 0 : 1);
    end
    g = 1;
    while (g < run_start.size()) begin
      int k = run_start[g];
      int dur = run_len[g];
      if (dur >= int'(LONG)) begin
        mark_set(k + int'(LONG) - 1, 3);
        for (int t = k + int'(LONG) - 1; t < k + dur; t++) mark_set(t, 5);
        g += 2;
      end else if (g + 1 >= run_start.size()) begin
        break;
      end else if (run_len[g + 1] >= int'(GAP)) begin
        mark_set(run_start[g + 1] + int'(GAP) - 1, 2);
        g += 2;
      end else begin
        if (g + 2 < run_start.size()) mark_set(run_start[g + 2], 4);
        g += 4;
      end
    end
  endfunction

  initial begin
    // Reset with db high, then first press
    add(1, 1, Z, 0, 2);
    add(0, 1, PT, 1, 1);
    // Short press: 3 high, 5 low
    add(0, 1, Z, 1, 2);  add(0, 0, RT, 1, 1); add(0, 0, Z, 1, 3); add(0, 0, SP, 1, 1);
    // 7 high: still a short press
    add(0, 1, PT, 2, 1); add(0, 1, Z, 2, 6);  add(0, 0, RT, 2, 1);
    add(0, 0, Z, 2, 3);  add(0, 0, SP, 2, 1);
    // 8 high: long press, held 2 more, no short afterwards
    add(0, 1, PT, 3, 1); add(0, 1, Z, 3, 6);  add(0, 1, LP | LA, 3, 1);
    add(0, 1, LA, 3, 2); add(0, 0, RT, 3, 1); add(0, 0, Z, 3, 6);
    // Double press: high 2, low 3, high 2, low
    add(0, 1, PT, 0, 1); add(0, 1, Z, 0, 1);  add(0, 0, RT, 0, 1); add(0, 0, Z, 0, 2);
    add(0, 1, PT | DP, 1, 1); add(0, 1, Z, 1, 1); add(0, 0, RT, 1, 1); add(0, 0, Z, 1, 6);
    // Gap boundary: low 4 still double
    add(0, 1, PT, 2, 1); add(0, 1, Z, 2, 1);  add(0, 0, RT, 2, 1); add(0, 0, Z, 2, 3);
    add(0, 1, PT | DP, 3, 1); add(0, 0, RT, 3, 1); add(0, 0, Z, 3, 6);
    // Gap boundary: low 5 gives short, next press is a new gesture
    add(0, 1, PT, 0, 1); add(0, 1, Z, 0, 1);  add(0, 0, RT, 0, 1); add(0, 0, Z, 0, 3);
    add(0, 0, SP, 0, 1); add(0, 1, PT, 1, 1); add(0, 0, RT, 1, 1); add(0, 0, Z, 1, 3);
    add(0, 0, SP, 1, 1);
    // Reset while waiting for a second press
    add(0, 1, PT, 2, 1); add(0, 1, Z, 2, 1);  add(0, 0, RT, 2, 1); add(0, 0, Z, 2, 1);
    add(1, 0, Z, 0, 1);  add(0, 0, Z, 0, 8);
    // Five single-sample presses, counter wraps
    for (int p = 1; p <= 5; p++) begin
      add(0, 1, PT, 2'(p), 1); add(0, 0, RT, 2'(p), 1);
      add(0, 0, Z, 2'(p), 3);  add(0, 0, SP, 2'(p), 1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d", i), obs, {vecs[i].f, vecs[i].c});
    end

    // Hand sequence: long hold, then reset aborts it while db stays high
    for (int i = 1; i <= 12; i++) begin
      step(0, 1);
      check($sformatf("hold%0d", i), {press_tick, long_press, long_active},
            {i == 1, i == int'(LONG), i >= int'(LONG)});
    end
    step(1, 1);
    check("hold_rst", obs, 8'h00);
    step(0, 1);
    check("hold_repress", obs, {PT, 2'd1});
    step(0, 0);
    check("hold_release", obs, {RT, 2'd1});

    // Random run-length stimulus against the gesture model
    build_random();
    step(1, 0);
    begin
      int pc = 0;
      for (int t = 0; t < N; t++) begin
        step(0, s_arr[t]);
        if (e_pt[t]) pc++;
        check($sformatf("rnd%0d", t), obs,
              {e_pt[t], e_rt[t], e_sp[t], e_lp[t], e_dp[t], e_la[t], 2'(pc)});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
